alu_op_scheduler: RTL and testbench

//  Shares one 8-bit multi-cycle ALU (BEGIN/END handshake, op/X/Y in, 16-bit OUT) between two requesters.

---
 rtl/alu_op_scheduler_pkg.sv | 22 ++
 rtl/alu_op_scheduler_rr_arbiter2.sv | 33 +++
 rtl/alu_op_scheduler.sv | 159 +++++++++++++++
 tb/tb_alu_op_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and widths for the ALU operation scheduler.
package alu_op_scheduler_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } alu_cmd_t;

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant_c
);

    logic last_grant;

    // Grant is only offered while the scheduler can accept a command.
    always_comb begin
        grant_c = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (|grant_c) begin
            last_grant <= grant_c[1];
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one multi-cycle ALU between two requesters: arbitrate, launch, wait for END or
// time out and recover the ALU, then return a tagged response.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT        = 64,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [OUT_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              alu_begin,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_resetn,
    input  logic              alu_end,
    input  logic [OUT_W-1:0]  alu_out,
    output logic              busy
);

    localparam int unsigned REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    state_t           state;
    state_t           state_next;
    alu_cmd_t         cmd_q;
    alu_cmd_t         cmd_sel_c;
    logic [1:0]       grant_c;
    logic             idle_c;
    logic             accept_c;
    logic             complete_c;
    logic             rec_done_c;
    logic             end_q;
    logic             cur_id;
    logic [CNT_W-1:0] wd_cnt;
    logic [REC_W-1:0] rec_cnt;

    assign idle_c = (state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (idle_c),
        .valid   ({req1_valid, req0_valid}),
        .grant_c (grant_c)
    );

    assign req0_ready = grant_c[0];
    assign req1_ready = grant_c[1];
    assign cmd_sel_c  = grant_c[1] ? {req1_op, req1_x, req1_y} : {req0_op, req0_x, req0_y};

    assign alu_op     = cmd_q.op;
    assign alu_x      = cmd_q.x;
    assign alu_y      = cmd_q.y;
    assign busy       = !idle_c;
    assign alu_resetn = resetn & (state != ST_RECOVER);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion is a rising END seen in WAIT; it takes priority over the watchdog.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        rec_done_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant_c) begin
                    accept_c   = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (alu_end && !end_q) begin
                    complete_c = 1'b1;
                    state_next = ST_RESP;
                end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt == REC_W'(RECOVER_CYCLES - 1)) begin
                    rec_done_c = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Watchdog counts cycles since BEGIN, so it reads TIMEOUT-1 exactly TIMEOUT-1 cycles later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_q     <= '0;
            cur_id    <= 1'b0;
            end_q     <= 1'b0;
            alu_begin <= 1'b0;
            wd_cnt    <= '0;
            rec_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            end_q     <= alu_end;
            alu_begin <= accept_c;
            rsp_valid <= (state_next == ST_RESP);
            if (accept_c) begin
                cmd_q  <= cmd_sel_c;
                cur_id <= grant_c[1];
                wd_cnt <= '0;
            end else if (state == ST_LAUNCH || state == ST_WAIT) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (state == ST_RECOVER) begin
                rec_cnt <= rec_cnt + REC_W'(1);
            end else begin
                rec_cnt <= '0;
            end
            if (complete_c) begin
                rsp_data <= alu_out;
                rsp_err  <= 1'b0;
                rsp_id   <= cur_id;
            end else if (rec_done_c) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                rsp_id   <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed and randomized checks of alu_op_scheduler against a requester/ALU model.
module tb_alu_op_scheduler;

    localparam int TIMEOUT = 64;
    localparam int REC     = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [7:0]  req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;
    logic        alu_begin, alu_resetn, alu_end, busy;
    logic [2:0]  alu_op;
    logic [7:0]  alu_x, alu_y;
    logic [15:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_scheduler #(.TIMEOUT(TIMEOUT), .RECOVER_CYCLES(REC), .CNT_W(7)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_begin(alu_begin), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
        .alu_resetn(alu_resetn), .alu_end(alu_end), .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub: END rises L cycles after BEGIN and stays high until the next BEGIN; OUT={X,Y}.
    int         stub_L = 10;
    int         stub_cnt = 0;
    bit         stub_hang = 1'b0;
    bit         stub_stale = 1'b0;
    bit         stub_active = 1'b0;
    bit         end_hold = 1'b0;
    logic [7:0] sx = 8'h00;
    logic [7:0] sy = 8'h00;

    always @(posedge clk) begin
        if (!alu_resetn) begin
            stub_active <= 1'b0;
            stub_cnt    <= 0;
            end_hold    <= 1'b0;
        end else if (alu_begin) begin
            stub_active <= 1'b1;
            stub_cnt    <= 1;
            sx          <= alu_x;
            sy          <= alu_y;
            end_hold    <= stub_stale ? alu_end : 1'b0;
        end else if (stub_active) begin
            if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 >= stub_L - 1) end_hold <= 1'b0;
        end
    end

    assign alu_end = end_hold | (stub_active && !stub_hang && stub_cnt >= stub_L);
    assign alu_out = {sx, sy};

    // Requester model: pending commands and the last requester granted.
    bit         p_v[2];
    logic [2:0] p_op[2];
    logic [7:0] p_x[2];
    logic [7:0] p_y[2];
    int         lg = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = p_v[0]; req0_op = p_op[0]; req0_x = p_x[0]; req0_y = p_y[0];
        req1_valid = p_v[1]; req1_op = p_op[1]; req1_x = p_x[1]; req1_y = p_y[1];
    endtask

    task automatic new_cmd(input int r, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        p_v[r] = 1'b1; p_op[r] = op; p_x[r] = x; p_y[r] = y;
    endtask

    function automatic int winner();
        if (p_v[0] && p_v[1]) return 1 - lg;
        if (p_v[0]) return 0;
        if (p_v[1]) return 1;
        return -1;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive();
        rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_begin", 32'(alu_begin), 32'd0);
        check("rst_alu_cmd", 32'({alu_op, alu_x, alu_y}), 32'd0);
        check("rst_alu_resetn", 32'(alu_resetn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        lg = 1;
    endtask

    task automatic finish_resp(input string tag, input int hold, input int w,
                               input logic [15:0] exp_data, input bit exp_err);
        if (hold > 0) begin
            rsp_ready = 1'b0;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, "_hold_rsp"}, 32'({rsp_id, rsp_err, rsp_data}), 32'({w[0], exp_err, exp_data}));
                check({tag, "_hold_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
                check({tag, "_hold_busy"}, 32'(busy), 32'd1);
                check({tag, "_hold_cmd"}, 32'({alu_op, alu_x, alu_y}), 32'({p_op[w], p_x[w], p_y[w]}));
            end
            drive();
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_idle"}, 32'({busy, alu_begin}), 32'd0);
    endtask

    task automatic issue(input string tag, input int lat, input bit hang, input bit stale, input int hold);
        int w;
        int k;
        int begins;
        int first_low;
        int low_cnt;
        int exp_k;
        logic [15:0] exp_data;
        stub_L = lat; stub_hang = hang; stub_stale = stale;
        drive();
        #1;
        w = winner();
        check({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'({w == 1, w == 0}));
        @(posedge clk);
        #1;
        lg = w;
        p_v[w] = 1'b0;
        drive();
        check({tag, "_begin"}, 32'(alu_begin), 32'd1);
        check({tag, "_cmd"}, 32'({alu_op, alu_x, alu_y}), 32'({p_op[w], p_x[w], p_y[w]}));
        k = 0; begins = 0; first_low = -1; low_cnt = 0;
        while (!rsp_valid && k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (alu_begin) begins++;
            if (!alu_resetn) begin
                if (first_low < 0) first_low = k;
                low_cnt++;
            end
        end
        exp_k    = hang ? (TIMEOUT + REC) : (lat + 1);
        exp_data = hang ? 16'h0000 : {p_x[w], p_y[w]};
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_single_begin"}, 32'(begins), 32'd0);
        if (hang) begin
            check({tag, "_rec_start"}, 32'(first_low), 32'(TIMEOUT));
            check({tag, "_rec_len"}, 32'(low_cnt), 32'(REC));
        end else begin
            check({tag, "_no_rec"}, 32'(low_cnt), 32'd0);
        end
        check({tag, "_id"}, 32'(rsp_id), 32'(w));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_err"}, 32'(rsp_err), 32'(hang));
        check({tag, "_cmd_held"}, 32'({alu_op, alu_x, alu_y}), 32'({p_op[w], p_x[w], p_y[w]}));
        finish_resp(tag, hold, w, exp_data, hang);
    endtask

    initial begin
        int seen;
        resetn = 1'b1;
        rsp_ready = 1'b1;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive();
        #2;
        do_reset();

        // Basic operation, L=10
        new_cmd(0, 3'b100, 8'h0C, 8'h03);
        issue("t1", 10, 1'b0, 1'b0, 0);

        // Round-robin ties straight after reset
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            new_cmd(0, 3'($urandom), 8'($urandom), 8'($urandom));
            new_cmd(1, 3'($urandom), 8'($urandom), 8'($urandom));
            issue($sformatf("t2_%0da", rep), 5, 1'b0, 1'b0, 0);
            issue($sformatf("t2_%0db", rep), 7, 1'b0, 1'b0, 0);
        end

        // Consumer back-pressure
        new_cmd(1, 3'($urandom), 8'($urandom), 8'($urandom));
        issue("t3", 4, 1'b0, 1'b0, 5);

        // Hung ALU -> watchdog abort
        new_cmd(0, 3'($urandom), 8'($urandom), 8'($urandom));
        issue("t4", 10, 1'b1, 1'b0, 0);

        // END rises on the last watchdog cycle: completion wins
        new_cmd(1, 3'($urandom), 8'($urandom), 8'($urandom));
        issue("t_wd_edge", TIMEOUT - 1, 1'b0, 1'b0, 0);

        // Stale END from previous op
        new_cmd(0, 3'($urandom), 8'($urandom), 8'($urandom));
        issue("t5", 6, 1'b0, 1'b1, 0);

        // Reset during WAIT drops the command
        new_cmd(0, 3'($urandom), 8'($urandom), 8'($urandom));
        stub_L = 20; stub_stale = 1'b0;
        drive();
        @(posedge clk);
        #1;
        p_v[0] = 1'b0;
        drive();
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_begin", 32'(alu_begin), 32'd0);
        check("t6_rst_alu_resetn", 32'(alu_resetn), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        lg = 1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen++;
        end
        check("t6_no_rsp", 32'(seen), 32'd0);
        new_cmd(1, 3'b001, 8'hFF, 8'h01);
        issue("t6", 5, 1'b0, 1'b0, 0);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(1, 0) == 1)
                    new_cmd(r, 3'($urandom), 8'($urandom), 8'($urandom));
            end
            if (!p_v[0] && !p_v[1])
                new_cmd(int'($urandom_range(1, 0)), 3'($urandom), 8'($urandom), 8'($urandom));
            issue($sformatf("rnd%0d", it), int'($urandom_range(12, 3)), 1'b0,
                  1'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
